// File: rtl/alu_issue_wb_pkg.sv
// Shared widths, ALU opcode encodings and the instruction record for the
// operand-issue / write-back stage.
package alu_issue_wb_pkg;

  localparam int NREG = 8;
  localparam int DW   = 8;
  localparam int RW   = $clog2(NREG);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_GT  = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          use_imm;
    logic [DW-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction, ALU and result signals of the issue/write-back stage.
// master = instruction source, ALU and result sink; slave = the stage itself.
interface alu_issue_wb_if;
  import alu_issue_wb_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic          in_use_imm;
  logic [DW-1:0] in_imm;

  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic          alu_carry;
  logic [DW-1:0] alu_out;

  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_rd;
  logic [DW-1:0] res_data;
  logic          res_carry;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  in_ready,
    input  alu_ctrl, alu_x, alu_y,
    output alu_carry, alu_out,
    input  res_valid, res_rd, res_data, res_carry,
    output res_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output in_ready,
    output alu_ctrl, alu_x, alu_y,
    input  alu_carry, alu_out,
    output res_valid, res_rd, res_data, res_carry,
    input  res_ready
  );

endinterface

// File: rtl/alu_issue_wb_regfile.sv
// Architectural register file: two async operand read ports, one async debug
// read port, one synchronous write port, cleared by the async reset.
module alu_regfile #(
  parameter  int NREG = 8,
  parameter  int DW   = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = rf_q[raddr1_i];
  assign rdata2_o   = rf_q[raddr2_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_wb.sv
// Two-stage operand-issue (EX) and write-back/result (RES) stage around an
// external combinational ALU, with EX-stage bypass and valid/ready handshakes.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_wb_if.slave           bus,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  output logic [DW-1:0]           dbg_data_o,
  output logic                    carry_flag_o
);

  instr_t ins;

  logic          ex_valid_q, ex_valid_d;
  logic [2:0]    ex_rd_q, ex_rd_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0] alu_x_q, alu_x_d;
  logic [DW-1:0] alu_y_q, alu_y_d;

  logic          res_valid_q, res_valid_d;
  logic [2:0]    res_rd_q, res_rd_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  logic          carry_flag_q, carry_flag_d;

  logic          res_free, ex_adv, accept;
  logic [DW-1:0] rs1_rf, rs2_rf, opnd_x, opnd_y;

  always_comb begin
    ins.op      = bus.in_op;
    ins.rd      = bus.in_rd;
    ins.rs1     = bus.in_rs1;
    ins.rs2     = bus.in_rs2;
    ins.use_imm = bus.in_use_imm;
    ins.imm     = bus.in_imm;
  end

  assign res_free     = !res_valid_q || bus.res_ready;
  assign ex_adv       = ex_valid_q && res_free;
  assign bus.in_ready = !ex_valid_q || res_free;
  assign accept       = bus.in_valid && bus.in_ready;

  alu_regfile #(.NREG(NREG), .DW(DW)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (ex_adv),
    .waddr_i    (ex_rd_q),
    .wdata_i    (bus.alu_out),
    .raddr1_i   (ins.rs1),
    .rdata1_o   (rs1_rf),
    .raddr2_i   (ins.rs2),
    .rdata2_o   (rs2_rf),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // The only un-written producer is the one in EX; RES results are already in rf.
  assign opnd_x = (ex_valid_q && ex_rd_q == ins.rs1) ? bus.alu_out : rs1_rf;
  assign opnd_y = ins.use_imm                          ? ins.imm     :
                  (ex_valid_q && ex_rd_q == ins.rs2)   ? bus.alu_out : rs2_rf;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rd_d      = ex_rd_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    res_valid_d  = res_valid_q;
    res_rd_d     = res_rd_q;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    carry_flag_d = carry_flag_q;

    if (accept) begin
      alu_ctrl_d = ins.op;
      alu_x_d    = opnd_x;
      alu_y_d    = opnd_y;
      ex_rd_d    = ins.rd;
      ex_valid_d = 1'b1;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end

    // Writeback happens on the EX->RES move, independent of the result handshake.
    if (ex_adv) begin
      res_rd_d     = ex_rd_q;
      res_data_d   = bus.alu_out;
      res_carry_d  = bus.alu_carry;
      res_valid_d  = 1'b1;
      carry_flag_d = bus.alu_carry;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
      alu_ctrl_q   <= '0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      res_valid_q  <= 1'b0;
      res_rd_q     <= '0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      res_valid_q  <= res_valid_d;
      res_rd_q     <= res_rd_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign carry_flag_o  = carry_flag_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb: directed instructions push hand-computed
// results; a negedge monitor pops and compares every result handshake.
module tb_alu_issue_wb;
  import alu_issue_wb_pkg::*;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    logic       carry;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       carry_flag;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  alu_issue_wb_if bus ();

  alu_issue_wb #(.NREG(8), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data),
    .carry_flag_o (carry_flag)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
    bus.alu_out   = 8'h00;
    bus.alu_carry = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin bus.alu_out = alu_sum[7:0]; bus.alu_carry = alu_sum[8]; end
      OP_SUB: begin bus.alu_out = bus.alu_x - bus.alu_y; bus.alu_carry = (bus.alu_x < bus.alu_y); end
      OP_AND: bus.alu_out = bus.alu_x & bus.alu_y;
      OP_OR:  bus.alu_out = bus.alu_x | bus.alu_y;
      OP_XOR: bus.alu_out = bus.alu_x ^ bus.alu_y;
      OP_SHL: bus.alu_out = bus.alu_y << bus.alu_x[2:0];
      OP_SHR: bus.alu_out = bus.alu_y >> bus.alu_x[2:0];
      OP_EQ:  bus.alu_out = {7'b0, bus.alu_x == bus.alu_y};
      default: bus.alu_out = 8'h00;
    endcase
  end

  // Monitor: compare every accepted result against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got rd=%0d data=%02h carry=%0b, required none",
                 bus.res_rd, bus.res_data, bus.res_carry);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.res_rd !== e.rd || bus.res_data !== e.data || bus.res_carry !== e.carry) begin
          failures++;
          $display("FAIL result: got rd=%0d data=%02h carry=%0b, required rd=%0d data=%02h carry=%0b",
                   bus.res_rd, bus.res_data, bus.res_carry, e.rd, e.data, e.carry);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic chk_reg(input logic [2:0] r, input logic [7:0] req);
    dbg_addr = r;
    #1;
    chk($sformatf("dbg_r%0d", r), dbg_data, req);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm,
                       input bit push, input logic [7:0] ed, input logic ec);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    if (bus.in_ready && push) sb.push_back('{rd, ed, ec});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
    bus.res_ready = 1'b1;
    dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", {7'b0, bus.res_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, bus.in_ready}, 8'h01);
    chk("rst_alu_x", bus.alu_x, 8'h00);
    chk("rst_alu_ctrl", {4'b0, bus.alu_ctrl}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_carry_flag", {7'b0, carry_flag}, 8'h00);
    for (int r = 0; r < 8; r++) chk_reg(3'(r), 8'h00);

    // Reset while an instruction sits in EX: it must vanish
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {7'b0, bus.res_valid}, 8'h00);
    chk("midrst_alu_x", bus.alu_x, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reg(3'd2, 8'h00);
    chk("midrst_res_valid_after", {7'b0, bus.res_valid}, 8'h00);

    // Immediate add back-to-back with bypass and carry
    issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0);
    issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 8'hFE, 1'b1, 8'h03, 1'b1);
    drain();
    chk("add_carry_flag", {7'b0, carry_flag}, 8'h01);
    chk_reg(3'd1, 8'h03);

    // Subtract and shift, each operand bypassed from the previous instruction
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0);
    issue(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 8'h03, 1'b1, 8'h03, 1'b0);
    issue(OP_SUB, 3'd4, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 8'h0D, 1'b0);
    issue(OP_SHL, 3'd5, 3'd3, 3'd4, 1'b0, 8'h00, 1'b1, 8'h68, 1'b0);
    drain();
    chk_reg(3'd4, 8'h0D);
    chk_reg(3'd5, 8'h68);
    chk("sub_carry_flag", {7'b0, carry_flag}, 8'h00);

    // Back-pressure: two accepted, third held off while RES is stalled
    bus.res_ready = 1'b0;
    issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0);
    issue(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 8'h22, 1'b1, 8'h22, 1'b0);
    bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_rd = 3'd6; bus.in_rs1 = 3'd6;
    bus.in_use_imm = 1'b1; bus.in_imm = 8'h01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", {7'b0, bus.in_ready}, 8'h00);
      chk("stall_res_valid", {7'b0, bus.res_valid}, 8'h01);
      chk("stall_res_data", bus.res_data, 8'h11);
      chk("stall_res_rd", {5'b0, bus.res_rd}, 8'h06);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    issue(OP_ADD, 3'd6, 3'd6, 3'd0, 1'b1, 8'h01, 1'b1, 8'h12, 1'b0);
    drain();
    chk_reg(3'd6, 8'h12);
    chk_reg(3'd7, 8'h22);

    // Compare, carry-producing add, then an undefined opcode
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0);
    issue(OP_EQ,  3'd3, 3'd2, 3'd0, 1'b1, 8'h5A, 1'b1, 8'h01, 1'b0);
    issue(OP_ADD, 3'd5, 3'd2, 3'd0, 1'b1, 8'hC0, 1'b1, 8'h1A, 1'b1);
    drain();
    chk("pre_undef_carry_flag", {7'b0, carry_flag}, 8'h01);
    issue(4'b1110, 3'd4, 3'd2, 3'd0, 1'b1, 8'h77, 1'b1, 8'h00, 1'b0);
    drain();
    chk_reg(3'd3, 8'h01);
    chk_reg(3'd4, 8'h00);
    chk("undef_carry_flag", {7'b0, carry_flag}, 8'h00);

    // Dependency chain on r1 while res_ready toggles every cycle
    fork
      begin
        for (int c = 0; c < 30; c++) begin
          @(posedge clk);
          #1;
          bus.res_ready = ~bus.res_ready;
        end
        bus.res_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++)
          issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01, 1'b1, 8'(4 + k), 1'b0);
      end
    join
    drain();
    chk_reg(3'd1, 8'h09);
    chk("final_sb_empty", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
